regfile_write_arbiter: RTL

//  Shares the 16x16 register file write ports among three writeback sources: ALU, memory load and mul/div.

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the regfile general and r0 write ports among ALU, MEM and mul/div writeback.
module regfile_write_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              md_valid,
    input  logic [DATA_W-1:0] md_r0_data,
    input  logic              md_rem_en,
    input  logic [ADDR_W-1:0] md_rem_reg,
    input  logic [DATA_W-1:0] md_rem_data,
    output logic              md_ready,
    output logic [1:0]        registerWrite,
    output logic [ADDR_W-1:0] regWriteLocal,
    output logic [DATA_W-1:0] dataWrite,
    output logic [DATA_W-1:0] r0Write,
    output logic              wr_busy
);
    typedef enum logic {MD_IDLE, MD_REM_PEND} md_state_t;
    md_state_t         state, state_next;
    logic              rr_last;
    logic [ADDR_W-1:0] rem_reg;
    logic [DATA_W-1:0] rem_data;
    logic              md_acc, alu_ok, mem_ok, alu_first;
    logic              g_rem, g_alu, g_mem;
    logic [ADDR_W-1:0] gen_reg;
    logic [DATA_W-1:0] gen_data;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= MD_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == MD_IDLE && md_acc && md_rem_en)
            state_next = MD_REM_PEND;
        else if (state == MD_REM_PEND && g_rem)
            state_next = MD_IDLE;
    end

    always_comb begin
        md_ready = reset_n && state == MD_IDLE;
    end

    // A general write to r0 would collide with the r0 port in the same cycle, so it is held back.
    always_comb begin
        md_acc    = md_valid && md_ready;
        alu_ok    = reset_n && alu_valid && !(md_acc && alu_reg == '0);
        mem_ok    = reset_n && mem_valid && !(md_acc && mem_reg == '0);
        alu_first = (RR_ENABLE == 1'b0) || rr_last;
        g_rem     = reset_n && state == MD_REM_PEND;
        g_alu     = !g_rem && alu_ok && (!mem_ok || alu_first);
        g_mem     = !g_rem && mem_ok && (!alu_ok || !alu_first);
        gen_reg   = g_rem ? rem_reg : g_alu ? alu_reg : mem_reg;
        gen_data  = g_rem ? rem_data : g_alu ? alu_data : mem_data;
    end

    assign alu_ready = g_alu;
    assign mem_ready = g_mem;
    assign wr_busy   = (registerWrite != 2'b00) || state == MD_REM_PEND;

    // rr_last = 1 means MEM was granted last, so ALU wins the next tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            registerWrite <= 2'b00;
            regWriteLocal <= '0;
            dataWrite     <= '0;
            r0Write       <= '0;
            rem_reg       <= '0;
            rem_data      <= '0;
            rr_last       <= 1'b1;
        end else begin
            registerWrite <= {md_acc, g_rem || g_alu || g_mem};
            if (md_acc)
                r0Write <= md_r0_data;
            if (md_acc && md_rem_en) begin
                rem_reg  <= md_rem_reg;
                rem_data <= md_rem_data;
            end
            if (g_rem || g_alu || g_mem) begin
                regWriteLocal <= gen_reg;
                dataWrite     <= gen_data;
            end
            if (g_alu)
                rr_last <= 1'b0;
            else if (g_mem)
                rr_last <= 1'b1;
        end
    end
endmodule
